io_decimal_display: RTL and testbench

Signed-decimal seven-segment formatter on the output side of the I/O path. It captures the 32-bit signed value written by an OUT instruction and converts its magnitude to BCD with a sequential shift-add-3 (double-dabble) engine. It drives eight active-low seven-segment digits with a fixed-position minus sign, optional leading-zero blanking and an overflow indication. It replaces raw hex display of output data with human-readable decimal.

---
 rtl/io_decimal_display.sv | 201 ++++++++++++++++++++
 tb/tb_io_decimal_display.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/io_decimal_display.sv
// -----------------------------------------------------------------------------
// io_decimal_display
//
// Signed-decimal seven-segment formatter for OUT instruction data. A value is
// captured on Start, its magnitude is converted to BCD with a sequential
// shift-add-3 (double-dabble) engine, and eight active-low digits are rendered
// with a fixed-position minus sign, optional leading-zero blanking and an
// overflow indication (all digits show minus).
//
// Parameters
//   LEADING_ZERO_BLANK  1: blank digits above the most significant non-zero
//                          digit; 0: show them as '0'.
// Ports
//   Clock               rising-edge system clock
//   Reset               asynchronous, active-high reset
//   Start               conversion request, accepted only when idle
//   Value[31:0]         signed two's-complement value, sampled on accept
//   Busy                high from the accepting edge until the render edge
//   Done                one-cycle pulse following the render edge
//   Display0..Display7  active-low segments {g,f,e,d,c,b,a}, Display0 = LSD
// -----------------------------------------------------------------------------
module io_decimal_display #(
   parameter bit LEADING_ZERO_BLANK = 1'b1
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic [31:0] Value,
   output logic        Busy,
   output logic        Done,
   output logic [6:0]  Display0,
   output logic [6:0]  Display1,
   output logic [6:0]  Display2,
   output logic [6:0]  Display3,
   output logic [6:0]  Display4,
   output logic [6:0]  Display5,
   output logic [6:0]  Display6,
   output logic [6:0]  Display7
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONVERT,
      ST_RENDER
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b111_1111;
   localparam logic [6:0] SEG_MINUS = 7'b011_1111;
   localparam logic [6:0] SEG_ZERO  = 7'b100_0000;

   // Largest magnitudes that fit: seven digits behind a minus, or eight digits.
   localparam logic [31:0] NEG_LIMIT = 32'd9_999_999;
   localparam logic [31:0] POS_LIMIT = 32'd99_999_999;

   state_t      state_q, state_d;
   logic        sign_q, sign_d;
   logic        ovf_q, ovf_d;
   logic [31:0] mag_q, mag_d;
   logic [31:0] bcd_q, bcd_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [6:0]  disp_q [8];
   logic [6:0]  disp_d [8];

   logic [31:0] accept_mag;
   logic        accept_ovf;
   logic [31:0] bcd_adj;
   logic [63:0] shifted;
   logic [6:0]  render_disp [8];

   function automatic logic [6:0] seg_of(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'b100_0000;
         4'd1:    seg = 7'b111_1001;
         4'd2:    seg = 7'b010_0100;
         4'd3:    seg = 7'b011_0000;
         4'd4:    seg = 7'b001_1001;
         4'd5:    seg = 7'b001_0010;
         4'd6:    seg = 7'b000_0010;
         4'd7:    seg = 7'b111_1000;
         4'd8:    seg = 7'b000_0000;
         4'd9:    seg = 7'b001_0000;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   // Two's-complement negate as unsigned: -2^31 maps onto 2^31, which the
   // overflow check then rejects.
   always_comb begin
      accept_mag = Value[31] ? (~Value + 32'd1) : Value;
      accept_ovf = Value[31] ? (accept_mag > NEG_LIMIT) : (accept_mag > POS_LIMIT);
   end

   // One double-dabble step: correct every nibble that would overflow past 9
   // after doubling, then shift the magnitude's next bit into the BCD field.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                        : bcd_q[4*i +: 4];
      end
      shifted = {bcd_adj, mag_q} << 1;
   end

   // Render image from the finished BCD register.
   always_comb begin
      int top_idx;
      top_idx = 0;
      for (int i = 0; i < 8; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) top_idx = i;
      end
      for (int i = 0; i < 8; i++) begin
         render_disp[i] = seg_of(bcd_q[4*i +: 4]);
         // Display0 is never above top_idx, so it always shows its digit.
         if (LEADING_ZERO_BLANK && (i > top_idx)) render_disp[i] = SEG_BLANK;
         if (sign_q && (i == 7))                  render_disp[i] = SEG_MINUS;
         if (ovf_q)                               render_disp[i] = SEG_MINUS;
      end
   end

   // NOTE: every signal written here gets its hold value first, so no path
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      ovf_d   = ovf_q;
      mag_d   = mag_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      disp_d  = disp_q;

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               sign_d  = Value[31];
               mag_d   = accept_mag;
               ovf_d   = accept_ovf;
               bcd_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = accept_ovf ? ST_RENDER : ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            bcd_d = shifted[63:32];
            mag_d = shifted[31:0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = ST_RENDER;
         end
         ST_RENDER: begin
            disp_d  = render_disp;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its _d value from before the edge, independent of statement order.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         sign_q  <= 1'b0;
         ovf_q   <= 1'b0;
         mag_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < 8; i++) disp_q[i] <= SEG_ZERO;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         ovf_q   <= ovf_d;
         mag_q   <= mag_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         disp_q  <= disp_d;
      end
   end

   assign Busy     = busy_q;
   assign Done     = done_q;
   assign Display0 = disp_q[0];
   assign Display1 = disp_q[1];
   assign Display2 = disp_q[2];
   assign Display3 = disp_q[3];
   assign Display4 = disp_q[4];
   assign Display5 = disp_q[5];
   assign Display6 = disp_q[6];
   assign Display7 = disp_q[7];

endmodule

// File: tb/tb_io_decimal_display.sv
// -----------------------------------------------------------------------------
// tb_io_decimal_display
//
// Drives two instances (leading-zero blanking on and off) with the same
// stimulus and compares latency, Busy/Done behaviour and all eight displays
// against an arithmetic model of the signed decimal rendering.
// -----------------------------------------------------------------------------
module tb_io_decimal_display;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] value;

   logic        busy_a, done_a, busy_b, done_b;
   logic [6:0]  da [8];
   logic [6:0]  db [8];

   int n_checks = 0;
   int n_errors = 0;

   io_decimal_display #(.LEADING_ZERO_BLANK(1'b1)) u_blank (
      .Clock(clk), .Reset(rst), .Start(start), .Value(value),
      .Busy(busy_a), .Done(done_a),
      .Display0(da[0]), .Display1(da[1]), .Display2(da[2]), .Display3(da[3]),
      .Display4(da[4]), .Display5(da[5]), .Display6(da[6]), .Display7(da[7])
   );

   io_decimal_display #(.LEADING_ZERO_BLANK(1'b0)) u_zeros (
      .Clock(clk), .Reset(rst), .Start(start), .Value(value),
      .Busy(busy_b), .Done(done_b),
      .Display0(db[0]), .Display1(db[1]), .Display2(db[2]), .Display3(db[3]),
      .Display4(db[4]), .Display5(db[5]), .Display6(db[6]), .Display7(db[7])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [55:0] disp_a();
      return {da[7], da[6], da[5], da[4], da[3], da[2], da[1], da[0]};
   endfunction

   function automatic logic [55:0] disp_b();
      return {db[7], db[6], db[5], db[4], db[3], db[2], db[1], db[0]};
   endfunction

   function automatic logic [6:0] seg_digit(input int d);
      case (d)
         0: return 7'b100_0000;
         1: return 7'b111_1001;
         2: return 7'b010_0100;
         3: return 7'b011_0000;
         4: return 7'b001_1001;
         5: return 7'b001_0010;
         6: return 7'b000_0010;
         7: return 7'b111_1000;
         8: return 7'b000_0000;
         9: return 7'b001_0000;
         default: return 7'b111_1111;
      endcase
   endfunction

   function automatic bit is_ovf(input int v);
      longint m;
      m = (v < 0) ? -longint'(v) : longint'(v);
      return (v < 0) ? (m > 64'sd9_999_999) : (m > 64'sd99_999_999);
   endfunction

   // Expected {Display7..Display0} from plain decimal arithmetic.
   function automatic logic [55:0] model(input int v, input bit lzb);
      longint m;
      int     dig [8];
      int     top;
      logic [55:0] r;
      if (is_ovf(v)) return {8{7'b011_1111}};
      m = (v < 0) ? -longint'(v) : longint'(v);
      top = 0;
      for (int i = 0; i < 8; i++) begin
         dig[i] = int'(m % 10);
         m = m / 10;
         if (dig[i] != 0) top = i;
      end
      for (int i = 0; i < 8; i++) begin
         r[7*i +: 7] = (lzb && i > top) ? 7'b111_1111 : seg_digit(dig[i]);
      end
      if (v < 0) r[55:49] = 7'b011_1111;
      return r;
   endfunction

   // One conversion; optionally pulses Start with another value before edge
   // N+inject_at, which must be ignored.
   task automatic run_tx(input int v, input int inject_at, input int inject_v);
      int lat;
      bit busy_ok;
      logic [55:0] exp_a, exp_b;
      exp_a = model(v, 1'b1);
      exp_b = model(v, 1'b0);
      @(negedge clk);
      start = 1'b1;
      value = v;
      @(posedge clk);
      #1;
      start = 1'b0;
      value = $urandom;
      check($sformatf("busy_accept[%0d]", v), {busy_a, busy_b}, 2'b11);
      lat = 0;
      busy_ok = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         if (k == inject_at) begin
            start = 1'b1;
            value = inject_v;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done_a) begin
            lat = k;
            break;
         end
         if (!busy_a || !busy_b) busy_ok = 1'b0;
      end
      check($sformatf("latency[%0d]", v), lat, is_ovf(v) ? 1 : 33);
      check($sformatf("busy_held[%0d]", v), busy_ok, 1'b1);
      check($sformatf("done_busy_render[%0d]", v), {done_a, done_b, busy_a, busy_b}, 4'b1100);
      check($sformatf("disp_blank[%0d]", v), disp_a(), exp_a);
      check($sformatf("disp_zeros[%0d]", v), disp_b(), exp_b);
      @(posedge clk);
      #1;
      check($sformatf("done_pulse[%0d]", v), {done_a, done_b}, 2'b00);
      check($sformatf("disp_hold[%0d]", v), {disp_a(), disp_b()}, {exp_a, exp_b});
   endtask

   initial begin
      int lim, mag, v;
      rst   = 1'b1;
      start = 1'b0;
      value = '0;
      #12;
      check("reset_busy_done", {busy_a, done_a, busy_b, done_b}, 4'b0000);
      check("reset_disp", {disp_a(), disp_b()}, {16{7'b100_0000}});
      @(negedge clk);
      rst = 1'b0;

      // Directed cases from the boundary list.
      run_tx(1234, 0, 0);
      run_tx(-5, 0, 0);
      run_tx(0, 0, 0);
      run_tx(100_000_000, 0, 0);
      run_tx(int'(32'h8000_0000), 0, 0);
      run_tx(99_999_999, 0, 0);
      run_tx(-9_999_999, 0, 0);
      run_tx(-10_000_000, 0, 0);
      run_tx(10_000_000, 0, 0);
      run_tx(2147483647, 0, 0);

      // Start during conversion is ignored.
      run_tx(4321, 10, 987);

      // Reset in the middle of a conversion.
      @(negedge clk);
      start = 1'b1;
      value = 777;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midreset_busy_done", {busy_a, done_a, busy_b, done_b}, 4'b0000);
      check("midreset_disp", {disp_a(), disp_b()}, {16{7'b100_0000}});
      repeat (3) begin
         @(posedge clk);
         #1;
         check("midreset_no_done", {done_a, done_b, busy_a, busy_b}, 4'b0000);
      end
      @(negedge clk);
      rst = 1'b0;
      run_tx(-60_042, 0, 0);

      // Randomized values over all magnitudes, both signs.
      for (int t = 0; t < 24; t++) begin
         lim = 1;
         repeat ($urandom_range(1, 9)) lim = lim * 10;
         mag = int'($urandom % lim);
         v = ($urandom_range(0, 1) == 1) ? -mag : mag;
         run_tx(v, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
